// File: rtl/cvxif_copro_responder.sv
// rtl/cvxif_copro_responder.sv - CV-X-IF coprocessor responder: custom-3 decode, in-order commit buffer, execute FSM
module cvxif_copro_responder #(
   parameter int XLEN       = 32,
   parameter int ID_WIDTH   = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int MULTI_LAT  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  issue_valid_i,
   output logic                  issue_ready_o,
   input  logic [31:0]           issue_instr_i,
   input  logic [ID_WIDTH-1:0]   issue_id_i,
   input  logic [2*XLEN-1:0]     issue_rs_i,
   input  logic [1:0]            issue_rs_valid_i,
   output logic                  issue_accept_o,
   output logic                  issue_writeback_o,
   input  logic                  commit_valid_i,
   input  logic [ID_WIDTH-1:0]   commit_id_i,
   input  logic                  commit_kill_i,
   output logic                  result_valid_o,
   input  logic                  result_ready_i,
   output logic [ID_WIDTH-1:0]   result_id_o,
   output logic [XLEN-1:0]       result_data_o,
   output logic [4:0]            result_rd_o,
   output logic                  result_we_o,
   output logic                  busy_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(MULTI_LAT + 1);

   localparam logic [1:0] OP_XOR  = 2'd1;
   localparam logic [1:0] OP_NOP  = 2'd2;
   localparam logic [1:0] OP_MADD = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXEC   = 2'd1,
      S_RESULT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic                dec_legal;
   logic [1:0]          dec_op;
   logic                unused_instr;

   logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]       wr_idx, rd_idx;
   logic                empty, full, push, pop;
   logic                head_start, head_drop, exec_done;

   logic [FIFO_DEPTH-1:0] ent_valid_q, ent_valid_d;
   logic [FIFO_DEPTH-1:0] ent_cmt_q, ent_cmt_d;
   logic [ID_WIDTH-1:0]   ent_id_q  [FIFO_DEPTH];
   logic [4:0]            ent_rd_q  [FIFO_DEPTH];
   logic [1:0]            ent_op_q  [FIFO_DEPTH];
   logic [XLEN-1:0]       ent_rs1_q [FIFO_DEPTH];
   logic [XLEN-1:0]       ent_rs2_q [FIFO_DEPTH];

   logic [ID_WIDTH-1:0] ex_id_q;
   logic [4:0]          ex_rd_q;
   logic [1:0]          ex_op_q;
   logic [XLEN-1:0]     ex_rs1_q, ex_rs2_q;
   logic [CW-1:0]       cnt_q;
   logic [XLEN-1:0]     exec_data;

   logic [ID_WIDTH-1:0] res_id_q;
   logic [XLEN-1:0]     res_data_q;
   logic [4:0]          res_rd_q;
   logic                res_we_q;

   // custom-3 with funct3 000..011 is the only legal space
   always_comb begin
      dec_legal = (issue_instr_i[6:0] == 7'b1111011) && !issue_instr_i[14];
      dec_op    = issue_instr_i[13:12];
   end

   assign unused_instr      = ^issue_instr_i[31:15];
   assign issue_accept_o    = dec_legal;
   assign issue_writeback_o = dec_legal && (dec_op != OP_NOP);

   assign wr_idx = wr_ptr_q[AW-1:0];
   assign rd_idx = rd_ptr_q[AW-1:0];
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

   assign issue_ready_o = !full && (issue_rs_valid_i == 2'b11);
   assign push          = issue_valid_i && issue_ready_o && dec_legal;

   // a killed entry still occupies its slot until it reaches the head
   assign head_start = (state_q == S_IDLE) && !empty && ent_valid_q[rd_idx] && ent_cmt_q[rd_idx];
   assign head_drop  = (state_q == S_IDLE) && !empty && !ent_valid_q[rd_idx];
   assign pop        = head_start || head_drop;
   assign exec_done  = (state_q == S_EXEC) && (cnt_q == CW'(1));

   assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
   assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

   always_comb begin
      ent_valid_d = ent_valid_q;
      ent_cmt_d   = ent_cmt_q;
      if (commit_valid_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_valid_q[i] && (ent_id_q[i] == commit_id_i)) begin
               if (commit_kill_i) ent_valid_d[i] = 1'b0;
               else               ent_cmt_d[i]   = 1'b1;
            end
         end
      end
      if (pop) begin
         ent_valid_d[rd_idx] = 1'b0;
         ent_cmt_d[rd_idx]   = 1'b0;
      end
      if (push) begin
         ent_valid_d[wr_idx] = 1'b1;
         ent_cmt_d[wr_idx]   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ent_valid_q <= '0;
         ent_cmt_q   <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         ent_valid_q <= ent_valid_d;
         ent_cmt_q   <= ent_cmt_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            ent_id_q[i]  <= '0;
            ent_rd_q[i]  <= '0;
            ent_op_q[i]  <= '0;
            ent_rs1_q[i] <= '0;
            ent_rs2_q[i] <= '0;
         end
      end else if (push) begin
         ent_id_q[wr_idx]  <= issue_id_i;
         ent_rd_q[wr_idx]  <= issue_instr_i[11:7];
         ent_op_q[wr_idx]  <= dec_op;
         ent_rs1_q[wr_idx] <= issue_rs_i[XLEN-1:0];
         ent_rs2_q[wr_idx] <= issue_rs_i[2*XLEN-1:XLEN];
      end
   end

   always_comb begin
      case (ex_op_q)
         OP_XOR:  exec_data = ex_rs1_q ^ ex_rs2_q;
         OP_NOP:  exec_data = '0;
         default: exec_data = ex_rs1_q + ex_rs2_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_id_q    <= '0;
         ex_rd_q    <= '0;
         ex_op_q    <= '0;
         ex_rs1_q   <= '0;
         ex_rs2_q   <= '0;
         cnt_q      <= '0;
         res_id_q   <= '0;
         res_data_q <= '0;
         res_rd_q   <= '0;
         res_we_q   <= 1'b0;
      end else begin
         if (head_start) begin
            ex_id_q  <= ent_id_q[rd_idx];
            ex_rd_q  <= ent_rd_q[rd_idx];
            ex_op_q  <= ent_op_q[rd_idx];
            ex_rs1_q <= ent_rs1_q[rd_idx];
            ex_rs2_q <= ent_rs2_q[rd_idx];
            cnt_q    <= (ent_op_q[rd_idx] == OP_MADD) ? CW'(MULTI_LAT) : CW'(1);
         end else if (state_q == S_EXEC) begin
            cnt_q <= cnt_q - CW'(1);
         end
         if (exec_done) begin
            res_id_q   <= ex_id_q;
            res_data_q <= exec_data;
            res_rd_q   <= ex_rd_q;
            res_we_q   <= (ex_op_q != OP_NOP);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (head_start)     state_d = S_EXEC;
         S_EXEC:   if (exec_done)      state_d = S_RESULT;
         S_RESULT: if (result_ready_i) state_d = S_IDLE;
         default:                      state_d = S_IDLE;
      endcase
   end

   always_comb begin
      result_valid_o = (state_q == S_RESULT);
      busy_o         = !empty || (state_q != S_IDLE);
   end

   assign result_id_o   = res_id_q;
   assign result_data_o = res_data_q;
   assign result_rd_o   = res_rd_q;
   assign result_we_o   = res_we_q;

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// tb/tb_cvxif_copro_responder.sv - self-checking bench for cvxif_copro_responder
module tb_cvxif_copro_responder;

   localparam int XLEN  = 32;
   localparam int IDW   = 4;
   localparam int DEPTH = 4;
   localparam int LAT   = 4;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              issue_valid_i;
   logic              issue_ready_o;
   logic [31:0]       issue_instr_i;
   logic [IDW-1:0]    issue_id_i;
   logic [2*XLEN-1:0] issue_rs_i;
   logic [1:0]        issue_rs_valid_i;
   logic              issue_accept_o;
   logic              issue_writeback_o;
   logic              commit_valid_i;
   logic [IDW-1:0]    commit_id_i;
   logic              commit_kill_i;
   logic              result_valid_o;
   logic              result_ready_i;
   logic [IDW-1:0]    result_id_o;
   logic [XLEN-1:0]   result_data_o;
   logic [4:0]        result_rd_o;
   logic              result_we_o;
   logic              busy_o;

   cvxif_copro_responder #(
      .XLEN(XLEN), .ID_WIDTH(IDW), .FIFO_DEPTH(DEPTH), .MULTI_LAT(LAT)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
      .issue_rs_i(issue_rs_i), .issue_rs_valid_i(issue_rs_valid_i),
      .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
      .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
      .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
      .result_id_o(result_id_o), .result_data_o(result_data_o),
      .result_rd_o(result_rd_o), .result_we_o(result_we_o),
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [IDW-1:0]  id;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
      logic            we;
   } exp_t;

   exp_t pend[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   occ      = 0;

   function automatic logic [XLEN-1:0] ref_data(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
      case (f3)
         3'd0, 3'd3: return a + b;
         3'd1:       return a ^ b;
         default:    return '0;
      endcase
   endfunction

   function automatic bit ref_legal(input logic [31:0] instr);
      return (instr[6:0] == 7'h7B) && (instr[14:12] <= 3'd3);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_issue(input logic [31:0] instr, input logic [IDW-1:0] id,
                           input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2);
      bit   legal;
      exp_t e;
      legal            = ref_legal(instr);
      issue_instr_i    = instr;
      issue_id_i       = id;
      issue_rs_i       = {rs2, rs1};
      issue_valid_i    = 1'b1;
      #1;
      chk("issue_ready", issue_ready_o, occ < DEPTH);
      chk("issue_accept", issue_accept_o, legal);
      chk("issue_writeback", issue_writeback_o, legal && (instr[14:12] != 3'd2));
      tick();
      issue_valid_i = 1'b0;
      if (legal) begin
         e.id   = id;
         e.rd   = instr[11:7];
         e.data = ref_data(instr[14:12], rs1, rs2);
         e.we   = (instr[14:12] != 3'd2);
         pend.push_back(e);
         occ++;
      end
   endtask

   task automatic do_commit(input logic [IDW-1:0] id, input logic kill);
      commit_valid_i = 1'b1;
      commit_id_i    = id;
      commit_kill_i  = kill;
      tick();
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
      if (kill) begin
         for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].id == id) begin
               pend.delete(i);
               break;
            end
         end
      end
   endtask

   task automatic commit_timed(input logic [IDW-1:0] id, input int exp_lat, input string tag);
      int k;
      k              = 0;
      commit_valid_i = 1'b1;
      commit_id_i    = id;
      commit_kill_i  = 1'b0;
      do begin
         tick();
         k++;
         commit_valid_i = 1'b0;
      end while (!result_valid_o && k < 40);
      chk(tag, k, exp_lat);
   endtask

   task automatic wait_valid(input string tag);
      int k;
      k = 0;
      while (!result_valid_o && k < 40) begin
         tick();
         k++;
      end
      chk(tag, result_valid_o, 1'b1);
   endtask

   task automatic get_result(input string tag);
      exp_t e;
      wait_valid({tag, "_valid"});
      if (pend.size() != 0) e = pend.pop_front();
      else begin
         e.id = '0; e.rd = '0; e.data = '0; e.we = 1'b0;
      end
      chk({tag, "_id"}, result_id_o, e.id);
      chk({tag, "_rd"}, result_rd_o, e.rd);
      chk({tag, "_data"}, result_data_o, e.data);
      chk({tag, "_we"}, result_we_o, e.we);
      result_ready_i = 1'b1;
      tick();
      result_ready_i = 1'b0;
      chk({tag, "_valid_drop"}, result_valid_o, 1'b0);
   endtask

   task automatic drain_check(input string tag);
      repeat (4) tick();
      chk(tag, busy_o, 1'b0);
      occ = 0;
   endtask

   initial begin
      logic [31:0]    rw;
      logic [IDW-1:0] bid [3];
      logic [IDW-1:0] next_id;
      int             n;
      exp_t           e;

      issue_valid_i    = 1'b0;
      issue_instr_i    = '0;
      issue_id_i       = '0;
      issue_rs_i       = '0;
      issue_rs_valid_i = 2'b11;
      commit_valid_i   = 1'b0;
      commit_id_i      = '0;
      commit_kill_i    = 1'b0;
      result_ready_i   = 1'b0;
      rst_i            = 1'b1;
      repeat (3) tick();
      chk("rst_issue_ready", issue_ready_o, 1'b1);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_res_valid", result_valid_o, 1'b0);
      chk("rst_res_id", result_id_o, 0);
      chk("rst_res_data", result_data_o, 0);
      chk("rst_res_rd", result_rd_o, 0);
      chk("rst_res_we", result_we_o, 1'b0);
      rst_i = 1'b0;
      tick();

      do_issue(32'h0020_807B, 4'd3, 32'd5, 32'd7);
      commit_timed(4'd3, 3, "add_latency");
      get_result("add");
      drain_check("add_drain");

      do_issue(32'h0000_0033, 4'd4, 32'd1, 32'd2);
      repeat (3) begin
         tick();
         chk("op_busy", busy_o, 1'b0);
         chk("op_no_result", result_valid_o, 1'b0);
      end

      issue_rs_valid_i = 2'b10;
      #1;
      chk("rs_invalid_ready", issue_ready_o, 1'b0);
      issue_rs_valid_i = 2'b11;

      for (int i = 0; i < 4; i++) begin
         rw = $urandom;
         do_issue(32'h0000_22FB, IDW'(i), rw, ~rw);
      end
      #1;
      chk("full_ready", issue_ready_o, 1'b0);
      chk("full_busy", busy_o, 1'b1);
      do_commit(4'd0, 1'b1);
      for (int i = 1; i < 4; i++) do_commit(IDW'(i), 1'b0);
      repeat (3) get_result("nop");
      drain_check("nop_drain");

      do_issue(32'h0000_33FB, 4'd9, 32'hFFFF_FFFF, 32'd2);
      commit_timed(4'd9, LAT + 2, "madd_latency");
      get_result("madd");
      drain_check("madd_drain");

      rw = $urandom;
      do_issue(32'h0000_017B, 4'd10, rw, 32'h1234_5678);
      rw = $urandom;
      do_issue(32'h0000_11FB, 4'd11, rw, 32'hA5A5_0F0F);
      do_commit(4'd10, 1'b0);
      do_commit(4'd11, 1'b0);
      wait_valid("bp_wait");
      e = pend[0];
      repeat (5) begin
         chk("bp_valid", result_valid_o, 1'b1);
         chk("bp_id", result_id_o, e.id);
         chk("bp_data", result_data_o, e.data);
         chk("bp_rd", result_rd_o, e.rd);
         chk("bp_we", result_we_o, e.we);
         tick();
      end
      get_result("bp0");
      get_result("bp1");
      drain_check("bp_drain");

      next_id = 4'd0;
      repeat (8) begin
         n = $urandom_range(1, 3);
         for (int j = 0; j < n; j++) begin
            rw         = $urandom;
            rw[6:0]    = ($urandom_range(0, 3) == 0) ? 7'h33 : 7'h7B;
            rw[14:12]  = 3'($urandom_range(0, 7));
            bid[j]     = next_id;
            next_id    = next_id + 4'd1;
            do_issue(rw, bid[j], $urandom, $urandom);
         end
         for (int j = 0; j < n; j++) do_commit(bid[j], $urandom_range(0, 3) == 0);
         n = pend.size();
         repeat (n) get_result("rnd");
         drain_check("rnd_drain");
      end

      do_issue(32'h0020_807B, 4'd12, $urandom, $urandom);
      do_commit(4'd12, 1'b0);
      wait_valid("rst_mid_wait");
      rst_i = 1'b1;
      #1;
      chk("rst_mid_valid", result_valid_o, 1'b0);
      chk("rst_mid_busy", busy_o, 1'b0);
      chk("rst_mid_data", result_data_o, 0);
      pend.delete();
      occ = 0;
      tick();
      tick();
      rst_i = 1'b0;
      #1;
      chk("rst_post_ready", issue_ready_o, 1'b1);
      tick();
      do_issue(32'h0000_10FB, 4'd1, 32'h0F0F_0F0F, 32'hFF00_FF00);
      commit_timed(4'd1, 3, "post_rst_latency");
      get_result("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
